// File: rtl/ram_loader_pkg.sv
// Shared definitions for the sample-RAM loader: status codes, FSM encoding
// and the RAM size shared with the acquire and transmit blocks.
package ram_loader_pkg;

  localparam int RAM_SIZE_DEFAULT = 1536;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_BADLEN  = 2'd1;
  localparam logic [1:0] ST_CSUM    = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_FINISH,
    S_WAIT_RELEASE
  } state_t;

endpackage

// File: rtl/ram_loader_timeout.sv
// Inter-byte watchdog: cleared on every kick or while disabled, flags expiry
// once LIMIT-1 idle cycles have elapsed with the counter enabled.
module timeout_counter #(
  parameter int LIMIT = 2_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!enable || kick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/ram_loader.sv
// UART-to-RAM upload engine: takes one framed byte stream per grant
// (length lo/hi, payload, 8-bit sum) and writes the payload from address 0.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int RAM_SIZE       = RAM_SIZE_DEFAULT,
  parameter int ADDR_W         = 11,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              grant,
  input  logic [7:0]        rx_data,
  input  logic              rx_data_fresh,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              wr_en,
  output logic              done,
  output logic [1:0]        status,
  output logic [ADDR_W-1:0] load_count
);

  state_t            state;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        csum;
  logic [15:0]       len_full;
  logic              tmo_enable;
  logic              tmo_expired;

  assign len_full   = {rx_data, len_q[7:0]};
  assign tmo_enable = (state == S_LEN_HI) || (state == S_DATA) || (state == S_CSUM);

  timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (tmo_enable),
    .kick    (rx_data_fresh),
    .expired (tmo_expired)
  );

  // Priority inside each receiving state: grant drop, then fresh byte, then timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      len_q      <= '0;
      idx        <= '0;
      csum       <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_en      <= 1'b0;
      done       <= 1'b0;
      status     <= ST_OK;
      load_count <= '0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          idx  <= '0;
          csum <= '0;
          if (grant) state <= S_LEN_LO;
        end
        S_LEN_LO: begin
          if (!grant) begin
            state <= S_IDLE;
          end else if (rx_data_fresh) begin
            len_q <= ADDR_W'(rx_data);
            state <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (!grant) begin
            state <= S_IDLE;
          end else if (rx_data_fresh) begin
            if (len_full == 16'd0 || len_full > 16'(RAM_SIZE)) begin
              state      <= S_FINISH;
              done       <= 1'b1;
              status     <= ST_BADLEN;
              load_count <= idx;
            end else begin
              len_q <= len_full[ADDR_W-1:0];
              state <= S_DATA;
            end
          end else if (tmo_expired) begin
            state      <= S_FINISH;
            done       <= 1'b1;
            status     <= ST_TIMEOUT;
            load_count <= idx;
          end
        end
        S_DATA: begin
          if (!grant) begin
            state <= S_IDLE;
          end else if (rx_data_fresh) begin
            wr_en   <= 1'b1;
            wr_data <= rx_data;
            wr_addr <= idx;
            idx     <= idx + 1'b1;
            csum    <= csum + rx_data;
            if (idx == len_q - 1'b1) state <= S_CSUM;
          end else if (tmo_expired) begin
            state      <= S_FINISH;
            done       <= 1'b1;
            status     <= ST_TIMEOUT;
            load_count <= idx;
          end
        end
        S_CSUM: begin
          if (!grant) begin
            state <= S_IDLE;
          end else if (rx_data_fresh) begin
            state      <= S_FINISH;
            done       <= 1'b1;
            status     <= (rx_data == csum) ? ST_OK : ST_CSUM;
            load_count <= idx;
          end else if (tmo_expired) begin
            state      <= S_FINISH;
            done       <= 1'b1;
            status     <= ST_TIMEOUT;
            load_count <= idx;
          end
        end
        // done is raised on entry, so the FINISH cycle is the pulse itself.
        S_FINISH: begin
          state <= S_WAIT_RELEASE;
        end
        S_WAIT_RELEASE: begin
          if (!grant) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader with a short watchdog (100 cycles); every
// expected value below is hand-computed from the frame format.
module tb_ram_loader;

  logic        clk;
  logic        rst_n;
  logic        grant;
  logic [7:0]  rx_data;
  logic        rx_data_fresh;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        done;
  logic [1:0]  status;
  logic [10:0] load_count;

  int vectors;
  int miscompares;
  int write_count;
  int done_count;
  int w0;
  int d0;
  int k;
  logic [7:0] sum;

  ram_loader #(
    .RAM_SIZE       (1536),
    .ADDR_W         (11),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .grant         (grant),
    .rx_data       (rx_data),
    .rx_data_fresh (rx_data_fresh),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_en         (wr_en),
    .done          (done),
    .status        (status),
    .load_count    (load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each posedge sees the output value of the cycle that just ended.
  always @(posedge clk) begin
    if (wr_en === 1'b1) write_count++;
    if (done === 1'b1) done_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    rx_data       = b;
    rx_data_fresh = 1'b1;
    @(negedge clk);
    rx_data_fresh = 1'b0;
  endtask

  task automatic sendData(input logic [7:0] b, input logic [10:0] addr);
    applyStimulus(b);
    checkOutput("wr_en", {31'd0, wr_en}, 32'd1);
    checkOutput("wr_addr", {21'd0, wr_addr}, {21'd0, addr});
    checkOutput("wr_data", {24'd0, wr_data}, {24'd0, b});
  endtask

  task automatic checkDone(input string tag, input logic [1:0] st, input logic [10:0] lc);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, "_status"}, {30'd0, status}, {30'd0, st});
    checkOutput({tag, "_load_count"}, {21'd0, load_count}, {21'd0, lc});
  endtask

  task automatic releaseGrant();
    @(negedge clk);
    grant = 1'b0;
    repeat (3) @(negedge clk);
    grant = 1'b1;
    @(negedge clk);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_status"}, {30'd0, status}, 32'd0);
    checkOutput({tag, "_load_count"}, {21'd0, load_count}, 32'd0);
    checkOutput({tag, "_wr_addr"}, {21'd0, wr_addr}, 32'd0);
    checkOutput({tag, "_wr_data"}, {24'd0, wr_data}, 32'd0);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    write_count   = 0;
    done_count    = 0;
    rst_n         = 1'b0;
    grant         = 1'b0;
    rx_data       = 8'h00;
    rx_data_fresh = 1'b0;

    #12;
    checkReset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] good frame");
    grant = 1'b1;
    @(negedge clk);
    w0 = write_count;
    applyStimulus(8'h03);
    applyStimulus(8'h00);
    sendData(8'h11, 11'd0);
    sendData(8'h22, 11'd1);
    sendData(8'h33, 11'd2);
    applyStimulus(8'h66);
    checkDone("good", 2'd0, 11'd3);
    @(negedge clk);
    checkOutput("good_done_one_cycle", {31'd0, done}, 32'd0);
    checkOutput("good_write_total", write_count - w0, 32'd3);

    $display("[TB] grant held after done");
    w0 = write_count;
    d0 = done_count;
    applyStimulus(8'h44);
    applyStimulus(8'h55);
    repeat (3) @(negedge clk);
    checkOutput("rearm_writes", write_count - w0, 32'd0);
    checkOutput("rearm_done", done_count - d0, 32'd0);

    $display("[TB] bad checksum");
    releaseGrant();
    w0 = write_count;
    applyStimulus(8'h03);
    applyStimulus(8'h00);
    sendData(8'h11, 11'd0);
    sendData(8'h22, 11'd1);
    sendData(8'h33, 11'd2);
    applyStimulus(8'h65);
    checkDone("badsum", 2'd2, 11'd3);
    checkOutput("badsum_write_total", write_count - w0, 32'd3);

    $display("[TB] bad length zero");
    releaseGrant();
    w0 = write_count;
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    checkDone("len0", 2'd1, 11'd0);
    repeat (2) @(negedge clk);
    checkOutput("len0_writes", write_count - w0, 32'd0);

    $display("[TB] bad length 1537");
    releaseGrant();
    w0 = write_count;
    applyStimulus(8'h01);
    applyStimulus(8'h06);
    checkDone("len1537", 2'd1, 11'd0);
    repeat (2) @(negedge clk);
    checkOutput("len1537_writes", write_count - w0, 32'd0);

    $display("[TB] maximum length 1536");
    releaseGrant();
    w0 = write_count;
    sum = 8'h00;
    applyStimulus(8'h00);
    applyStimulus(8'h06);
    for (int i = 0; i < 1536; i++) begin
      applyStimulus(i[7:0]);
      sum = sum + i[7:0];
      checkOutput("max_wr_en", {31'd0, wr_en}, 32'd1);
      checkOutput("max_wr_addr", {21'd0, wr_addr}, i);
    end
    checkOutput("max_last_addr", {21'd0, wr_addr}, 32'd1535);
    applyStimulus(sum);
    checkDone("max", 2'd0, 11'd1536);
    checkOutput("max_write_total", write_count - w0, 32'd1536);

    $display("[TB] timeout");
    releaseGrant();
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    sendData(8'hAA, 11'd0);
    k = 0;
    while (done !== 1'b1 && k < 150) begin
      @(negedge clk);
      k++;
    end
    checkOutput("tmo_latency", k, 32'd100);
    checkDone("tmo", 2'd3, 11'd1);

    $display("[TB] byte in expiry cycle");
    releaseGrant();
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    sendData(8'hAA, 11'd0);
    repeat (98) @(negedge clk);
    sendData(8'hBB, 11'd1);
    checkOutput("expiry_no_done", {31'd0, done}, 32'd0);
    applyStimulus(8'h65);
    checkDone("expiry", 2'd0, 11'd2);

    $display("[TB] grant abort");
    releaseGrant();
    d0 = done_count;
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    sendData(8'hAA, 11'd0);
    @(negedge clk);
    grant = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("abort_no_done", done_count - d0, 32'd0);
    checkOutput("abort_status_held", {30'd0, status}, 32'd0);
    checkOutput("abort_load_count_held", {21'd0, load_count}, 32'd2);
    grant = 1'b1;
    @(negedge clk);
    applyStimulus(8'h03);
    applyStimulus(8'h00);
    sendData(8'h01, 11'd0);
    sendData(8'h02, 11'd1);
    sendData(8'h03, 11'd2);
    applyStimulus(8'h06);
    checkDone("after_abort", 2'd0, 11'd3);

    $display("[TB] grant drop coincident with fresh");
    releaseGrant();
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    w0 = write_count;
    @(negedge clk);
    grant         = 1'b0;
    rx_data       = 8'h77;
    rx_data_fresh = 1'b1;
    @(negedge clk);
    rx_data_fresh = 1'b0;
    checkOutput("coincident_wr_en", {31'd0, wr_en}, 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("coincident_writes", write_count - w0, 32'd0);
    grant = 1'b1;
    @(negedge clk);
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    sendData(8'h5A, 11'd0);
    applyStimulus(8'h5A);
    checkDone("after_coincident", 2'd0, 11'd1);

    $display("[TB] reset mid-DATA");
    releaseGrant();
    applyStimulus(8'h03);
    applyStimulus(8'h00);
    sendData(8'h11, 11'd0);
    sendData(8'h22, 11'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkReset("async_reset");
    @(negedge clk);
    grant = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post_reset_wr_en", {31'd0, wr_en}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- UART-to-RAM upload engine, the write-side counterpart of the transmit block.
- While granted by the task dispatcher, it accepts a framed byte stream from the UART receiver (rx_data / rx_data_fresh) and writes the payload into sample RAM at sequential addresses from 0.
- Reports completion and status to the dispatcher with a one-cycle done pulse.
- Frame format: length low, length high, payload bytes, checksum (8-bit sum of the payload, modulo 256).

Parameters:
RAM_SIZE  1536  highest legal payload length, in bytes
ADDR_W  11  width of wr_addr and of the length counters
TIMEOUT_CYCLES  2_500_000  maximum clk cycles allowed between bytes once a frame has started (100 ms at 25 MHz)

Ports:
clk  in  1  system clock, clk_FPGA domain
rst_n  in  1  asynchronous active-low reset
grant  in  1  level; high enables one frame upload
rx_data  in  8  received byte from the UART
rx_data_fresh  in  1  one-cycle strobe; rx_data is valid in that cycle
wr_addr  out  ADDR_W  RAM write address
wr_data  out  8  RAM write data
wr_en  out  1  RAM write strobe, one cycle per byte
done  out  1  one-cycle pulse at the end of a frame
status  out  2  result code, valid while done=1 and held until the next done: 0 OK, 1 bad length, 2 checksum error, 3 timeout
load_count  out  ADDR_W  number of payload bytes written in the last frame; held

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - wr_en=0, done=0, status=0, load_count=0, wr_addr=0, wr_data=0.
  - Timeout counter, length register and checksum accumulator are cleared.
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, FINISH, WAIT_RELEASE.
- IDLE: if grant=1, go to LEN_LO. Clear the checksum accumulator, the byte index and the timeout counter.
- LEN_LO: on fresh, latch len[7:0] and go to LEN_HI. No timeout applies in this state; the host may idle indefinitely before the first byte.
- LEN_HI: on fresh, form len = {rx_data, len[7:0]}.
  - If len=0 or len>RAM_SIZE: status=1, go to FINISH.
  - Otherwise go to DATA.
- DATA: on each fresh byte, in the following cycle:
  - wr_en=1, wr_data=byte, wr_addr=index.
  - Index increments and the checksum accumulates the byte (8-bit wrap).
  - After byte number len is written, go to CSUM.
  - Latency from fresh to wr_en is exactly 1 cycle.
- CSUM: on fresh, compare rx_data with the accumulator.
  - Equal: status=0. Unequal: status=2.
  - Go to FINISH.
- FINISH: assert done=1 for one cycle, set load_count=index, go to WAIT_RELEASE.
- WAIT_RELEASE: remain until grant=0, then go to IDLE. This guarantees one frame per grant assertion.
- Timeout:
  - The counter runs in LEN_HI, DATA and CSUM, and resets on every fresh byte.
  - When it reaches TIMEOUT_CYCLES-1: status=3, go to FINISH.
  - If a fresh byte and the timeout occur in the same cycle, the byte wins.
- Grant drop: grant=0 in LEN_LO, LEN_HI, DATA or CSUM aborts immediately to IDLE.
  - No done pulse; status and load_count keep their previous values.
  - If grant drops in the same cycle as a fresh byte, the abort wins and the byte is not written.
- Any fresh byte received in IDLE, FINISH or WAIT_RELEASE is ignored.
- Bytes already written on an error or abort remain in RAM; the dispatcher decides what to do with them.
- Address never exceeds len-1, which is at most RAM_SIZE-1, so no wrap-around is possible.
- wr_en is never asserted outside DATA.

Decomposition:
- Shared package:
  - status code constants: ST_OK, ST_BADLEN, ST_CSUM, ST_TIMEOUT.
  - state encoding.
  - RAM_SIZE default, shared with the acquire and transmit blocks.
- Sub-module: timeout_counter (reload on kick, count while enabled, expire flag). Everything else is inline.

Test Plan:
- Good frame:
  - Stimulus: grant=1; bytes 03 00 11 22 33, then checksum 66.
  - Required: three wr_en pulses, one cycle after each payload fresh, at addresses 0,1,2 with data 11,22,33; then done pulse with status=0 and load_count=3.
- Bad checksum:
  - Stimulus: same frame with checksum 65.
  - Required: three writes, then done with status=2 and load_count=3.
- Bad length:
  - Stimulus: length 00 00; separately, length 01 06 (=1537).
  - Required: done with status=1 right after the second byte, no wr_en.
  - Also: length 00 06 (=1536) is accepted and 1536 writes are performed, the last at address 1535.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=100; send 02 00 AA, then stall.
  - Required: done 100 cycles after the AA fresh with status=3 and load_count=1.
  - Also: a byte arriving in the expiry cycle is accepted instead.
- Grant abort:
  - Stimulus: grant drops after 02 00 AA.
  - Required: no done, FSM returns to IDLE; a new grant and full frame complete with status=0.
  - Also: grant drop coincident with fresh means no write occurs.
- Rearm and reset:
  - Stimulus: grant held high after done, then extra bytes sent.
  - Required: bytes ignored, no writes.
  - Stimulus: rst_n pulsed low mid-DATA.
  - Required: all outputs return to reset values immediately (asynchronously).
